// File: rtl/sat_round_pipe_if.sv
// Beat-level bus of the requantizer: input beat, output beat and saturation statistics.
// A beat moves across a boundary only in a cycle where valid and ready are both high; a
// sender holds valid and its payload until that happens, and ready never depends on valid.
interface sat_round_pipe_if #(
  parameter int NB_XI  = 17,
  parameter int NB_XO  = 9,
  parameter int N_CH   = 4,
  parameter int NB_CNT = 16
);
  logic                    i_valid;
  logic                    o_ready;
  logic [N_CH*NB_XI-1:0]   i_data;
  logic [1:0]              i_mode;
  logic                    i_clr_stat;
  logic                    o_valid;
  logic                    i_ready;
  logic [N_CH*NB_XO-1:0]   o_data;
  logic [N_CH-1:0]         o_sat;
  logic [N_CH-1:0]         o_sat_sticky;
  logic [NB_CNT-1:0]       o_sat_count;

  modport slave (
    input  i_valid, i_data, i_mode, i_clr_stat, i_ready,
    output o_ready, o_valid, o_data, o_sat, o_sat_sticky, o_sat_count
  );

  modport master (
    output i_valid, i_data, i_mode, i_clr_stat, i_ready,
    input  o_ready, o_valid, o_data, o_sat, o_sat_sticky, o_sat_count
  );
endinterface

// File: rtl/sat_round_pipe.sv
// Two-stage multi-channel requantizer: stage 1 rounds or rescales, stage 2 saturates.
// A single advance enable freezes the whole pipe under downstream backpressure.
module sat_round_pipe #(
  parameter int NB_XI  = 17,
  parameter int NBF_XI = 10,
  parameter int NB_XO  = 9,
  parameter int NBF_XO = 7,
  parameter int N_CH   = 4,
  parameter int NB_CNT = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  sat_round_pipe_if.slave  bus
);
  localparam int K_DROP = (NBF_XI > NBF_XO) ? (NBF_XI - NBF_XO) : 0;
  localparam int K_ADD  = (NBF_XO > NBF_XI) ? (NBF_XO - NBF_XI) : 0;
  localparam int W1     = NB_XI + 1 + K_ADD - K_DROP;
  localparam int WC     = ((W1 > NB_XO) ? W1 : NB_XO) + 1;

  localparam logic signed [WC-1:0] SAT_MAX = WC'((2 ** (NB_XO - 1)) - 1);
  localparam logic signed [WC-1:0] SAT_MIN = WC'(-(2 ** (NB_XO - 1)));
  localparam logic [NB_XO-1:0]     OUT_MAX = {1'b0, {(NB_XO-1){1'b1}}};
  localparam logic [NB_XO-1:0]     OUT_MIN = {1'b1, {(NB_XO-1){1'b0}}};

  logic                    en;
  logic                    xfer;
  logic                    v1;
  logic                    o_valid_q;
  logic [N_CH*W1-1:0]      s1_d;
  logic [N_CH*W1-1:0]      s1_q;
  logic [N_CH*NB_XO-1:0]   s2_d;
  logic [N_CH*NB_XO-1:0]   o_data_q;
  logic [N_CH-1:0]         sat_d;
  logic [N_CH-1:0]         o_sat_q;
  logic [N_CH-1:0]         sticky_q;
  logic [NB_CNT-1:0]       cnt_q;

  assign en   = !o_valid_q | bus.i_ready;
  assign xfer = o_valid_q & bus.i_ready;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [NB_XI-1:0]     x;
    logic [W1-1:0]        r;
    logic [W1-1:0]        q;
    logic signed [WC-1:0] v;
    logic [NB_XO-1:0]     y;
    logic                 s;

    assign x = bus.i_data[k*NB_XI +: NB_XI];

    if (K_DROP > 0) begin : g_drop
      localparam logic [NB_XI-1:0] STICKY_MASK = NB_XI'((64'd1 << (K_DROP - 1)) - 64'd1);
      logic [NB_XI-K_DROP-1:0] kept;
      logic                    guard;
      logic                    sticky;
      logic                    inc;

      assign kept   = x[NB_XI-1:K_DROP];
      assign guard  = x[K_DROP-1];
      assign sticky = |(x & STICKY_MASK);

      always_comb begin
        inc = 1'b0;
        case (bus.i_mode)
          2'b00:   inc = 1'b0;
          2'b01:   inc = guard;
          default: inc = guard & (sticky | kept[0]);
        endcase
      end

      // One extra MSB so a rounding carry out of the top is kept for stage 2.
      assign r = {kept[NB_XI-K_DROP-1], kept} + W1'(inc);
    end else begin : g_add
      logic [W1-1:0] ext;
      assign ext = {{(1 + K_ADD){x[NB_XI-1]}}, x};
      assign r   = ext << K_ADD;
    end

    assign s1_d[k*W1 +: W1] = r;

    assign q = s1_q[k*W1 +: W1];
    assign v = {{(WC - W1){q[W1-1]}}, q};

    always_comb begin
      y = v[NB_XO-1:0];
      s = 1'b0;
      if (v > SAT_MAX) begin
        y = OUT_MAX;
        s = 1'b1;
      end else if (v < SAT_MIN) begin
        y = OUT_MIN;
        s = 1'b1;
      end
    end

    assign s2_d[k*NB_XO +: NB_XO] = y;
    assign sat_d[k]               = s;
  end

  // Bubbles advance like beats; nothing moves while a held output waits for the sink.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      v1        <= 1'b0;
      o_valid_q <= 1'b0;
      s1_q      <= '0;
      o_data_q  <= '0;
      o_sat_q   <= '0;
    end else if (en) begin
      v1        <= bus.i_valid;
      o_valid_q <= v1;
      s1_q      <= s1_d;
      o_data_q  <= s2_d;
      o_sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else if (bus.i_clr_stat) begin
      if (xfer) begin
        sticky_q <= o_sat_q;
        cnt_q    <= NB_CNT'(|o_sat_q);
      end else begin
        sticky_q <= '0;
        cnt_q    <= '0;
      end
    end else if (xfer) begin
      sticky_q <= sticky_q | o_sat_q;
      if ((|o_sat_q) && (cnt_q != {NB_CNT{1'b1}})) begin
        cnt_q <= cnt_q + NB_CNT'(1);
      end
    end
  end

  assign bus.o_ready      = en;
  assign bus.o_valid      = o_valid_q;
  assign bus.o_data       = o_data_q;
  assign bus.o_sat        = o_sat_q;
  assign bus.o_sat_sticky = sticky_q;
  assign bus.o_sat_count  = cnt_q;
endmodule

// File: tb/tb_sat_round_pipe.sv
// Directed bench for sat_round_pipe: default build, a 2-bit counter build and a
// fraction-widening build share one clock and reset.
module tb_sat_round_pipe;
  logic clk;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  sat_round_pipe_if                   bus   ();
  sat_round_pipe_if #(.NB_CNT(2))     bus_c ();
  sat_round_pipe_if #(.NB_XI(12))     bus_k ();

  sat_round_pipe dut (.clk(clk), .i_rst(i_rst), .bus(bus));
  sat_round_pipe #(.NB_CNT(2)) dut_c (.clk(clk), .i_rst(i_rst), .bus(bus_c));
  sat_round_pipe #(.NB_XI(12), .NBF_XI(5)) dut_k (.clk(clk), .i_rst(i_rst), .bus(bus_k));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [67:0] pk_in(input int c3, input int c2, input int c1, input int c0);
    return {17'(c3), 17'(c2), 17'(c1), 17'(c0)};
  endfunction

  function automatic logic [35:0] pk_out(input int c3, input int c2, input int c1, input int c0);
    return {9'(c3), 9'(c2), 9'(c1), 9'(c0)};
  endfunction

  // driver: one beat through an idle pipe with i_ready high; called and returns at a negedge
  task automatic run_beat(input string tag, input logic [67:0] d, input logic [1:0] mode,
                          input logic clr, input logic [35:0] exp_d, input logic [3:0] exp_s);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_mode  = mode;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    chk({tag, "_early"}, 68'(bus.o_valid), 68'(1'b0));
    @(negedge clk);
    chk({tag, "_valid"}, 68'(bus.o_valid), 68'(1'b1));
    chk({tag, "_data"},  68'(bus.o_data),  68'(exp_d));
    chk({tag, "_sat"},   68'(bus.o_sat),   68'(exp_s));
    bus.i_clr_stat = clr;
    @(negedge clk);
    bus.i_clr_stat = 1'b0;
  endtask

  int rin [4] = '{1028, 1036, -1028, 1024};
  int rexp [4][3] = '{'{128, 129, 128}, '{129, 130, 130}, '{-129, -128, -128}, '{128, 128, 128}};
  int sin_v [5] = '{2048, -2048, -2056, 2044, 2044};
  int smode [5] = '{0, 0, 0, 1, 0};
  int sexp [5]  = '{255, -256, -256, 255, 255};
  int ssat [5]  = '{1, 0, 1, 1, 0};

  logic [35:0] exp_q[$];

  initial begin
    int   sent;
    int   got;
    logic m_v1;
    logic m_ov;
    logic rdy;
    logic en;

    i_rst = 1'b1;
    bus.i_valid = 1'b0;   bus.i_data = '0;   bus.i_mode = 2'b00;   bus.i_clr_stat = 1'b0;   bus.i_ready = 1'b1;
    bus_c.i_valid = 1'b0; bus_c.i_data = '0; bus_c.i_mode = 2'b00; bus_c.i_clr_stat = 1'b0; bus_c.i_ready = 1'b1;
    bus_k.i_valid = 1'b0; bus_k.i_data = '0; bus_k.i_mode = 2'b00; bus_k.i_clr_stat = 1'b0; bus_k.i_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid",  68'(bus.o_valid),      68'(1'b0));
    chk("rst_data",   68'(bus.o_data),       68'(0));
    chk("rst_sat",    68'(bus.o_sat),        68'(0));
    chk("rst_sticky", 68'(bus.o_sat_sticky), 68'(0));
    chk("rst_count",  68'(bus.o_sat_count),  68'(0));
    i_rst = 1'b0;
    #1;
    chk("rst_ready", 68'(bus.o_ready), 68'(1'b1));
    @(negedge clk);

    // rounding ties on ch0
    for (int i = 0; i < 4; i++) begin
      for (int m = 0; m < 3; m++) begin
        run_beat($sformatf("round_%0d_m%0d", rin[i], m), pk_in(0, 0, 0, rin[i]), 2'(m), 1'b0,
                 pk_out(0, 0, 0, rexp[i][m]), 4'b0000);
      end
    end
    chk("round_count", 68'(bus.o_sat_count), 68'(0));

    // saturation bounds and rounding carry
    for (int i = 0; i < 5; i++) begin
      run_beat($sformatf("sat_%0d_m%0d", sin_v[i], smode[i]), pk_in(0, 0, 0, sin_v[i]), 2'(smode[i]),
               1'b0, pk_out(0, 0, 0, sexp[i]), 4'(ssat[i]));
    end
    chk("sat_count",  68'(bus.o_sat_count),  68'(3));
    chk("sat_sticky", 68'(bus.o_sat_sticky), 68'(4'b0001));

    // mode change lands on the next beat while the previous one is in flight
    bus.i_valid = 1'b1; bus.i_data = pk_in(0, 0, 0, 1028); bus.i_mode = 2'b00;
    @(negedge clk);
    bus.i_data = pk_in(0, 0, 0, 1028); bus.i_mode = 2'b01;
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_mode = 2'b00;
    chk("mode_a", 68'(bus.o_data), 68'(pk_out(0, 0, 0, 128)));
    @(negedge clk);
    chk("mode_b", 68'(bus.o_data), 68'(pk_out(0, 0, 0, 129)));
    @(negedge clk);

    // backpressure stream with a scoreboard of expected beats
    sent = 0; got = 0; m_v1 = 1'b0; m_ov = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      chk("bp_valid", 68'(bus.o_valid), 68'(m_ov));
      if (m_ov) begin
        chk("bp_data", 68'(bus.o_data), 68'(exp_q[0]));
        chk("bp_sat",  68'(bus.o_sat),  68'(4'b1000));
      end
      rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      bus.i_ready = rdy;
      bus.i_valid = (sent < 8);
      bus.i_data  = pk_in(2048, sent * 8 + 7, -(sent * 8), sent * 16);
      #1;
      en = !m_ov | rdy;
      chk("bp_ready", 68'(bus.o_ready), 68'(en));
      if (m_ov && rdy) begin
        void'(exp_q.pop_front());
        got++;
      end
      if (en) begin
        if (bus.i_valid) begin
          exp_q.push_back(pk_out(255, sent, -sent, 2 * sent));
          sent++;
        end
        m_ov = m_v1;
        m_v1 = bus.i_valid;
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_data = '0;
    chk("bp_drain0", 68'(bus.o_valid), 68'(1'b0));
    @(negedge clk);
    chk("bp_drain1", 68'(bus.o_valid), 68'(1'b0));
    chk("bp_count",  68'(bus.o_sat_count), 68'(11));

    // clear without a transfer
    bus.i_clr_stat = 1'b1;
    @(negedge clk);
    bus.i_clr_stat = 1'b0;
    chk("clr_count",  68'(bus.o_sat_count),  68'(0));
    chk("clr_sticky", 68'(bus.o_sat_sticky), 68'(0));

    // three saturating beats on ch2, then clear coinciding with a saturating ch0 transfer
    for (int i = 0; i < 3; i++) begin
      run_beat("ch2", pk_in(0, 2048, 0, 0), 2'b00, 1'b0, pk_out(0, 255, 0, 0), 4'b0100);
    end
    chk("ch2_count",  68'(bus.o_sat_count),  68'(3));
    chk("ch2_sticky", 68'(bus.o_sat_sticky), 68'(4'b0100));
    run_beat("clrx", pk_in(0, 0, 0, 2048), 2'b00, 1'b1, pk_out(0, 0, 0, 255), 4'b0001);
    chk("clrx_count",  68'(bus.o_sat_count),  68'(1));
    chk("clrx_sticky", 68'(bus.o_sat_sticky), 68'(4'b0001));

    // reset with two beats in flight
    bus.i_valid = 1'b1; bus.i_data = pk_in(0, 0, 0, 2048);
    @(negedge clk);
    bus.i_data = pk_in(0, 0, 0, 1036);
    @(negedge clk);
    bus.i_valid = 1'b0; bus.i_data = '0;
    chk("mid_inflight", 68'(bus.o_valid), 68'(1'b1));
    #2 i_rst = 1'b1;
    #1;
    chk("mid_valid",  68'(bus.o_valid),      68'(1'b0));
    chk("mid_data",   68'(bus.o_data),       68'(0));
    chk("mid_sat",    68'(bus.o_sat),        68'(0));
    chk("mid_sticky", 68'(bus.o_sat_sticky), 68'(0));
    chk("mid_count",  68'(bus.o_sat_count),  68'(0));
    @(negedge clk);
    i_rst = 1'b0;
    #1;
    chk("post_ready", 68'(bus.o_ready), 68'(1'b1));
    @(negedge clk);
    chk("post_stale0", 68'(bus.o_valid), 68'(1'b0));
    @(negedge clk);
    chk("post_stale1", 68'(bus.o_valid), 68'(1'b0));
    run_beat("post", pk_in(0, 0, 8, 0), 2'b00, 1'b0, pk_out(0, 0, 1, 0), 4'b0000);

    // 2-bit counter build: five saturating beats back to back
    bus_c.i_valid = 1'b1; bus_c.i_data = pk_in(0, 0, 0, 2048);
    repeat (5) @(negedge clk);
    bus_c.i_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt2_count",  68'(bus_c.o_sat_count),  68'(3));
    chk("cnt2_sticky", 68'(bus_c.o_sat_sticky), 68'(4'b0001));
    chk("cnt2_idle",   68'(bus_c.o_valid),      68'(1'b0));

    // widening build: 5 fractional bits in, 7 out
    for (int m = 0; m < 3; m++) begin
      bus_k.i_valid = 1'b1; bus_k.i_mode = 2'(m); bus_k.i_data = {12'd0, 12'd0, 12'd0, 12'd32};
      @(negedge clk);
      bus_k.i_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("kadd_valid_m%0d", m), 68'(bus_k.o_valid), 68'(1'b1));
      chk($sformatf("kadd_data_m%0d", m),  68'(bus_k.o_data),  68'(pk_out(0, 0, 0, 128)));
      chk($sformatf("kadd_sat_m%0d", m),   68'(bus_k.o_sat),   68'(4'b0000));
      @(negedge clk);
    end
    bus_k.i_valid = 1'b1; bus_k.i_mode = 2'b01; bus_k.i_data = {12'd0, 12'd0, 12'd0, 12'd64};
    @(negedge clk);
    bus_k.i_valid = 1'b0;
    @(negedge clk);
    chk("kadd_sat_data", 68'(bus_k.o_data), 68'(pk_out(0, 0, 0, 255)));
    chk("kadd_sat_flag", 68'(bus_k.o_sat),  68'(4'b0001));
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
